// File: rtl/mpu_frame_packer_pkg.sv
// Shared definitions for mpu_frame_packer: state encoding, header defaults and
// the saturating counter helper.
package mpu_pkg_defs;

  localparam logic [7:0] HDR0_DEF    = 8'hAA;
  localparam logic [7:0] HDR1_DEF    = 8'h55;
  localparam int         MAX_LEN_DEF = 20;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LATCH   = 4'd1;
  localparam logic [3:0] ST_HDR0    = 4'd2;
  localparam logic [3:0] ST_HDR1    = 4'd3;
  localparam logic [3:0] ST_LEN     = 4'd4;
  localparam logic [3:0] ST_SEQ     = 4'd5;
  localparam logic [3:0] ST_RDREQ   = 4'd6;
  localparam logic [3:0] ST_RDWAIT  = 4'd7;
  localparam logic [3:0] ST_PAYLOAD = 4'd8;
  localparam logic [3:0] ST_CHK     = 4'd9;
  localparam logic [3:0] ST_DONE    = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_LATCH   = ST_LATCH,
    S_HDR0    = ST_HDR0,
    S_HDR1    = ST_HDR1,
    S_LEN     = ST_LEN,
    S_SEQ     = ST_SEQ,
    S_RDREQ   = ST_RDREQ,
    S_RDWAIT  = ST_RDWAIT,
    S_PAYLOAD = ST_PAYLOAD,
    S_CHK     = ST_CHK,
    S_DONE    = ST_DONE
  } state_e;

  function automatic logic [7:0] sat8_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mpu_frame_packer.sv
// Drains a sample set from the MPU receive FIFO and streams it to the UART as
// AA 55 LEN [SEQ] payload CHK. Define MPU_PKG_SEQ_EN to insert the SEQ byte.
//
// state   | meaning
// IDLE    | wait for Dat_Rdy or a pending request
// LATCH   | clamp FIFO level to MAX_LEN, clear checksum
// HDR0/1  | send header bytes
// LEN     | send payload length
// SEQ     | send sequence byte (MPU_PKG_SEQ_EN only)
// RDREQ   | one-cycle FIFO pop
// RDWAIT  | capture popped byte
// PAYLOAD | send payload byte
// CHK     | send checksum
// DONE    | frame complete, bump sequence
module mpu_frame_packer
  import mpu_pkg_defs::*;
#(
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter int         MAX_LEN = MAX_LEN_DEF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Dat_Rdy,
  input  logic [4:0] Rx_Dat_Cnt,
  input  logic [7:0] Rx_Dat,
  output logic       Rx_FIFO_RD_Req,
  output logic [7:0] Tx_Dat,
  output logic       Tx_Vld,
  input  logic       Tx_Rdy,
  output logic       Busy,
  output logic [7:0] Drop_Cnt
);

  localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] tx_dat_q, tx_dat_d;
  logic       pending_q, pending_d;
  logic [7:0] drop_q, drop_d;
`ifdef MPU_PKG_SEQ_EN
  logic [7:0] seq_q, seq_d;
`endif

  logic       hs;
  logic [4:0] lat_len;
  logic [7:0] chk_sum;

  assign hs      = Tx_Vld & Tx_Rdy;
  assign lat_len = (Rx_Dat_Cnt > MAX_LEN_L) ? MAX_LEN_L : Rx_Dat_Cnt;
  // Running sum including the byte currently being handed to the UART.
  assign chk_sum = chk_q + tx_dat_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    chk_d     = chk_q;
    tx_dat_d  = tx_dat_q;
    pending_d = pending_q;
    drop_d    = drop_q;
`ifdef MPU_PKG_SEQ_EN
    seq_d     = seq_q;
`endif

    if (state_q != S_IDLE && Dat_Rdy) begin
      if (pending_q) drop_d = sat8_inc(drop_q);
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (Dat_Rdy || pending_q) begin
          state_d   = S_LATCH;
          pending_d = pending_q & Dat_Rdy;
        end
      end
      S_LATCH: begin
        len_d = lat_len;
        rem_d = lat_len;
        chk_d = 8'd0;
        if (lat_len == 5'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_HDR0;
          tx_dat_d = HDR0;
        end
      end
      S_HDR0: begin
        if (hs) begin
          state_d  = S_HDR1;
          tx_dat_d = HDR1;
        end
      end
      S_HDR1: begin
        if (hs) begin
          state_d  = S_LEN;
          tx_dat_d = {3'b000, len_q};
        end
      end
      S_LEN: begin
        if (hs) begin
          chk_d = chk_sum;
`ifdef MPU_PKG_SEQ_EN
          state_d  = S_SEQ;
          tx_dat_d = seq_q;
`else
          state_d  = S_RDREQ;
`endif
        end
      end
`ifdef MPU_PKG_SEQ_EN
      S_SEQ: begin
        if (hs) begin
          chk_d   = chk_sum;
          state_d = S_RDREQ;
        end
      end
`endif
      S_RDREQ: state_d = S_RDWAIT;
      S_RDWAIT: begin
        tx_dat_d = Rx_Dat;
        state_d  = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (hs) begin
          chk_d = chk_sum;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d  = S_CHK;
            tx_dat_d = chk_sum;
          end else begin
            state_d = S_RDREQ;
          end
        end
      end
      S_CHK: begin
        if (hs) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef MPU_PKG_SEQ_EN
        seq_d   = seq_q + 8'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      len_q     <= 5'd0;
      rem_q     <= 5'd0;
      chk_q     <= 8'd0;
      tx_dat_q  <= 8'd0;
      pending_q <= 1'b0;
      drop_q    <= 8'd0;
`ifdef MPU_PKG_SEQ_EN
      seq_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      chk_q     <= chk_d;
      tx_dat_q  <= tx_dat_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
`ifdef MPU_PKG_SEQ_EN
      seq_q     <= seq_d;
`endif
    end
  end

  assign Rx_FIFO_RD_Req = (state_q == S_RDREQ);
  assign Tx_Vld   = state_q inside {S_HDR0, S_HDR1, S_LEN, S_SEQ, S_PAYLOAD, S_CHK};
  assign Busy     = state_q inside {S_HDR0, S_HDR1, S_LEN, S_SEQ, S_RDREQ,
                                    S_RDWAIT, S_PAYLOAD, S_CHK};
  assign Tx_Dat   = tx_dat_q;
  assign Drop_Cnt = drop_q;

endmodule

// File: tb/tb_mpu_frame_packer.sv
// Directed bench for mpu_frame_packer: FIFO/UART models on the falling edge,
// frames compared byte-by-byte against hand-computed streams.
module tb_mpu_frame_packer;

  typedef logic [7:0] bq_t[$];

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Dat_Rdy = 1'b0;
  logic [4:0] Rx_Dat_Cnt = 5'd0;
  logic [7:0] Rx_Dat = 8'd0;
  logic       Rx_FIFO_RD_Req;
  logic [7:0] Tx_Dat;
  logic       Tx_Vld;
  logic       Tx_Rdy = 1'b0;
  logic       Busy;
  logic [7:0] Drop_Cnt;

  mpu_frame_packer dut (
    .CLK(CLK), .RSTn(RSTn), .Dat_Rdy(Dat_Rdy), .Rx_Dat_Cnt(Rx_Dat_Cnt),
    .Rx_Dat(Rx_Dat), .Rx_FIFO_RD_Req(Rx_FIFO_RD_Req), .Tx_Dat(Tx_Dat),
    .Tx_Vld(Tx_Vld), .Tx_Rdy(Tx_Rdy), .Busy(Busy), .Drop_Cnt(Drop_Cnt)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] fifo_mem [0:255];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  pops = 0;
  int  underflow = 0;
  int  stab_err = 0;
  int  busy_cycles = 0;
  int  mode = 0;          // 0: always ready, 1: ~30% ready, 2: never ready
  bit  stab_en = 1'b0;
  logic [7:0] rx_bytes[$];
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'd0;

  always @(negedge CLK) begin
    case (mode)
      0:       Tx_Rdy = 1'b1;
      1:       Tx_Rdy = ($urandom_range(0, 9) < 3);
      default: Tx_Rdy = 1'b0;
    endcase
    if (stab_en && prev_vld && !prev_rdy && (!Tx_Vld || Tx_Dat !== prev_dat))
      stab_err++;
    if (Tx_Vld && Tx_Rdy) rx_bytes.push_back(Tx_Dat);
    if (Busy) busy_cycles++;
    if (Rx_FIFO_RD_Req) begin
      pops++;
      if (wr_ptr > rd_ptr) begin
        Rx_Dat = fifo_mem[rd_ptr % 256];
        rd_ptr++;
      end else begin
        underflow++;
      end
    end
    Rx_Dat_Cnt = (wr_ptr - rd_ptr > 31) ? 5'd31 : 5'(wr_ptr - rd_ptr);
    prev_vld = Tx_Vld;
    prev_rdy = Tx_Rdy;
    prev_dat = Tx_Dat;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  task automatic pulse_rdy();
    @(negedge CLK);
    Dat_Rdy = 1'b1;
    @(negedge CLK);
    Dat_Rdy = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int base, input int n);
    int k = 0;
    while (!((rx_bytes.size() - base >= n) && !Busy) && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check_eq({tag, "_done"}, 32'(k < 2000), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic compare_frame(input string tag, input int base, input bq_t exp);
    check_eq({tag, "_nbytes"}, 32'(rx_bytes.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i),
               (base + i < rx_bytes.size()) ? 32'(rx_bytes[base + i]) : 32'hFFFF_FFFF,
               32'(exp[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int pbase;
    int bbase;
    int k;
    int lows;
    bq_t e;

    repeat (3) @(negedge CLK);
    check_eq("rst_vld",  32'(Tx_Vld), 32'd0);
    check_eq("rst_dat",  32'(Tx_Dat), 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_req",  32'(Rx_FIFO_RD_Req), 32'd0);
    check_eq("rst_drop", 32'(Drop_Cnt), 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: basic three-byte frame, UART always ready
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    base = rx_bytes.size(); pbase = pops;
    pulse_rdy();
    wait_frame("s1", base, 7);
    e = '{8'hAA, 8'h55, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    compare_frame("s1", base, e);
    check_eq("s1_pops", 32'(pops - pbase), 32'd3);
    check_eq("s1_busy_low", 32'(Busy), 32'd0);

    // 2: same frame with a sluggish UART
    mode = 1; stab_en = 1'b1;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    base = rx_bytes.size(); pbase = pops;
    pulse_rdy();
    wait_frame("s2", base, 7);
    stab_en = 1'b0; mode = 0;
    compare_frame("s2", base, e);
    check_eq("s2_pops", 32'(pops - pbase), 32'd3);
    check_eq("s2_stable", 32'(stab_err), 32'd0);

    // 3: 25 bytes queued, clamp to 20, remainder carried to the next frame
    for (int i = 1; i <= 25; i++) push_byte(8'(i));
    base = rx_bytes.size(); pbase = pops;
    pulse_rdy();
    wait_frame("s3", base, 24);
    check_eq("s3_len", 32'(rx_bytes[base + 2]), 32'h14);
    check_eq("s3_chk", 32'(rx_bytes[base + 23]), 32'hE6);
    check_eq("s3_nbytes", 32'(rx_bytes.size() - base), 32'd24);
    check_eq("s3_pops", 32'(pops - pbase), 32'd20);
    check_eq("s3_left", 32'(wr_ptr - rd_ptr), 32'd5);
    base = rx_bytes.size();
    pulse_rdy();
    wait_frame("s3b", base, 9);
    e = '{8'hAA, 8'h55, 8'h05, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h78};
    compare_frame("s3b", base, e);

    // 4: start + pending + dropped request, then an empty-FIFO request
    push_byte(8'h11); push_byte(8'h22);
    base = rx_bytes.size();
    pulse_rdy();
    @(negedge CLK);
    push_byte(8'h33);
    Dat_Rdy = 1'b1;
    @(negedge CLK);
    Dat_Rdy = 1'b0;
    @(negedge CLK);
    Dat_Rdy = 1'b1;
    @(negedge CLK);
    Dat_Rdy = 1'b0;
    k = 0;
    while (Busy && k < 200) begin @(negedge CLK); k++; end
    lows = 0;
    while (!Busy && lows < 20) begin @(negedge CLK); lows++; end
    check_eq("s4_gap", 32'(lows), 32'd3);
    wait_frame("s4", base, 11);
    e = '{8'hAA, 8'h55, 8'h02, 8'h11, 8'h22, 8'h35, 8'hAA, 8'h55, 8'h01, 8'h33, 8'h34};
    compare_frame("s4", base, e);
    check_eq("s4_drop", 32'(Drop_Cnt), 32'd1);
    base = rx_bytes.size(); pbase = pops; bbase = busy_cycles;
    pulse_rdy();
    repeat (20) @(negedge CLK);
    check_eq("s4_empty_bytes", 32'(rx_bytes.size() - base), 32'd0);
    check_eq("s4_empty_busy", 32'(busy_cycles - bbase), 32'd0);
    check_eq("s4_empty_pops", 32'(pops - pbase), 32'd0);

    // 5: reset while the second payload byte waits for the UART
    push_byte(8'h10); push_byte(8'h20); push_byte(8'h30); push_byte(8'h40);
    base = rx_bytes.size(); pbase = pops;
    pulse_rdy();
    k = 0;
    while (pops - pbase < 2 && k < 200) begin @(negedge CLK); k++; end
    mode = 2;
    k = 0;
    while (!Tx_Vld && k < 10) begin @(negedge CLK); k++; end
    check_eq("s5_reached", 32'(Tx_Vld), 32'd1);
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("s5_rst_vld",  32'(Tx_Vld), 32'd0);
    check_eq("s5_rst_dat",  32'(Tx_Dat), 32'd0);
    check_eq("s5_rst_busy", 32'(Busy), 32'd0);
    check_eq("s5_rst_req",  32'(Rx_FIFO_RD_Req), 32'd0);
    check_eq("s5_rst_drop", 32'(Drop_Cnt), 32'd0);
    repeat (3) @(negedge CLK);
    check_eq("s5_pops", 32'(pops - pbase), 32'd2);
    check_eq("s5_partial", 32'(rx_bytes.size() - base), 32'd4);
    RSTn = 1'b1;
    mode = 0;
    repeat (2) @(negedge CLK);
    base = rx_bytes.size();
    pulse_rdy();
    wait_frame("s5b", base, 6);
    e = '{8'hAA, 8'h55, 8'h02, 8'h30, 8'h40, 8'h72};
    compare_frame("s5b", base, e);

    // 6: two frames of FF FF, with or without the sequence byte
    for (int f = 0; f < 2; f++) begin
      push_byte(8'hFF); push_byte(8'hFF);
      base = rx_bytes.size();
      pulse_rdy();
`ifdef MPU_PKG_SEQ_EN
      wait_frame($sformatf("s6_%0d", f), base, 7);
      e = '{8'hAA, 8'h55, 8'h02, 8'(f), 8'hFF, 8'hFF, 8'(f)};
`else
      wait_frame($sformatf("s6_%0d", f), base, 6);
      e = '{8'hAA, 8'h55, 8'h02, 8'hFF, 8'hFF, 8'h00};
`endif
      compare_frame($sformatf("s6_%0d", f), base, e);
    end

    check_eq("underflow", 32'(underflow), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
